// File: rtl/carrier_sequencer_pkg.sv
// Shared definitions for the sine carrier sequencer: FSM state encoding,
// default datapath widths and LUT depth.
package carrier_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int ACC_W_DEF  = 16;
    localparam int CNT_W_DEF  = 8;
    localparam int LUT_DEPTH  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_t;

endpackage

// File: rtl/carrier_sequencer_if.sv
// Control/DAC bundle between the host register logic, the sequencer and the
// LUT/DAC pins. With CARRIER_SEQ_PHASE_EN defined a start-phase input
// (phase_ofs) is added.
interface carrier_sequencer_if
    import carrier_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic              start;
    logic              stop;
    logic [ACC_W-1:0]  fcw;
    logic [CNT_W-1:0]  burst_len;
`ifdef CARRIER_SEQ_PHASE_EN
    logic [ADDR_W-1:0] phase_ofs;
`endif
    logic [ADDR_W-1:0] address;
    logic              clk_DA;
    logic              blank_DA_n;
    logic              sync_DA_n;
    logic              period_tick;
    logic              busy;
    logic              done;

`ifdef CARRIER_SEQ_PHASE_EN
    modport master (
        output start, stop, fcw, burst_len, phase_ofs,
        input  address, clk_DA, blank_DA_n, sync_DA_n, period_tick, busy, done
    );
    modport slave (
        input  start, stop, fcw, burst_len, phase_ofs,
        output address, clk_DA, blank_DA_n, sync_DA_n, period_tick, busy, done
    );
`else
    modport master (
        output start, stop, fcw, burst_len,
        input  address, clk_DA, blank_DA_n, sync_DA_n, period_tick, busy, done
    );
    modport slave (
        input  start, stop, fcw, burst_len,
        output address, clk_DA, blank_DA_n, sync_DA_n, period_tick, busy, done
    );
`endif

endinterface

// File: rtl/carrier_sequencer_phase_acc.sv
// Phase accumulator for the sine LUT: loadable start phase, gated advance by
// the frequency control word, carry-out marking a completed carrier period.
module carrier_phase_acc
    import carrier_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              adv_i,
    input  logic [ACC_W-1:0]  fcw_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              carry_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;

    assign sum     = {1'b0, acc_q} + {1'b0, fcw_i};
    assign carry_o = sum[ACC_W];
    assign addr_o  = acc_q[ACC_W-1 -: ADDR_W];

    // Next phase: load has priority over advance; otherwise hold.
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = {load_addr_i, {(ACC_W-ADDR_W){1'b0}}};
        end else if (adv_i) begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    // Phase register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/carrier_sequencer.sv
// Carrier sequencer: IDLE/ARM/RUN/STOP control of the phase accumulator and
// DAC strobes. One DAC sample per two clocks; the address advances on the
// clk_DA rising cycle so the registered LUT output settles before the next
// rising edge. Optional macro CARRIER_SEQ_PHASE_EN adds a start phase input.
module carrier_sequencer
    import carrier_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    carrier_sequencer_if.slave bus
);

    state_t            state_q, state_d;
    logic              ph_q, ph_d;
    logic              stop_pend_q, stop_pend_d;
    logic              tick_q, tick_d;
    logic [ACC_W-1:0]  fcw_q, fcw_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W:0]    cnt_inc;
    logic              acc_load, acc_adv, acc_carry;
    logic [ADDR_W-1:0] load_addr, addr;

`ifdef CARRIER_SEQ_PHASE_EN
    assign load_addr = bus.phase_ofs;
`else
    assign load_addr = '0;
`endif

    carrier_phase_acc #(
        .ADDR_W (ADDR_W),
        .ACC_W  (ACC_W)
    ) u_acc (
        .clk_i       (clk),
        .rst_i       (reset),
        .load_i      (acc_load),
        .load_addr_i (load_addr),
        .adv_i       (acc_adv),
        .fcw_i       (fcw_q),
        .addr_o      (addr),
        .carry_o     (acc_carry)
    );

    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // Next-state, latching and period bookkeeping.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        stop_pend_d = stop_pend_q;
        tick_d      = 1'b0;
        fcw_d       = fcw_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        acc_load    = 1'b0;
        acc_adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                fcw_d       = bus.fcw;
                burst_d     = bus.burst_len;
                cnt_d       = '0;
                stop_pend_d = 1'b0;
                ph_d        = 1'b1;
                acc_load    = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                ph_d    = ~ph_q;
                acc_adv = ~ph_q;
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
                if (acc_adv && acc_carry) begin
                    tick_d = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                    // A stop arriving on the wrap edge itself ends here too.
                    if (((burst_q != '0) && (cnt_inc == {1'b0, burst_q})) ||
                        stop_pend_q || bus.stop) begin
                        state_d = STOP;
                    end
                end
                // A zero FCW never wraps, so stop cannot wait for a boundary.
                if (bus.stop && (fcw_q == '0)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and latched-configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ph_q        <= 1'b0;
            stop_pend_q <= 1'b0;
            tick_q      <= 1'b0;
            fcw_q       <= '0;
            burst_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            stop_pend_q <= stop_pend_d;
            tick_q      <= tick_d;
            fcw_q       <= fcw_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.address     = addr;
    assign bus.clk_DA      = (state_q == RUN) && ph_q;
    assign bus.blank_DA_n  = (state_q == RUN);
    assign bus.sync_DA_n   = 1'b1;
    assign bus.period_tick = tick_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == STOP);

endmodule

// File: tb/tb_carrier_sequencer.sv
// Scoreboard bench for carrier_sequencer: a behavioural burst model predicts
// sample addresses, period ticks and done timing; a negedge monitor pops and
// compares whenever the DUT presents a sample, tick or done.
module tb_carrier_sequencer;

    typedef struct {
        int         cyc;
        logic [4:0] addr;
    } samp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;
    bit   mon_en;
    logic prev_cda;
    int   first_tick;
    int   last_done;
    samp_t sample_q[$];
    int    tick_q[$];
    int    done_q[$];
    samp_t mon_e;

    carrier_sequencer_if #(.ADDR_W(5), .ACC_W(16), .CNT_W(8)) bus ();

    carrier_sequencer #(.ADDR_W(5), .ACC_W(16), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Burst model: sample k shows in cycle s+2+2k with phase acc0+k*fcw;
    // a wrap of advance k ticks in cycle s+2+2k and may end the burst there.
    task automatic model_burst(input int s, input longint fcw, input int blen,
                               input int stop_c, input int ofs, output int d);
        longint acc0, a_prev, a;
        int     p;
        samp_t  t;
        acc0 = longint'(ofs) << 11;
        d    = -1;
        if (fcw == 0) begin
            for (int k = 0; s + 2 + 2 * k <= stop_c; k++) begin
                t.cyc  = s + 2 + 2 * k;
                t.addr = 5'(ofs);
                sample_q.push_back(t);
            end
            d = stop_c + 1;
            done_q.push_back(d);
            return;
        end
        p = 0;
        for (int k = 1; k <= 20000 && d < 0; k++) begin
            a_prev = acc0 + longint'(k - 1) * fcw;
            a      = acc0 + longint'(k) * fcw;
            t.cyc  = s + 2 * k;
            t.addr = 5'((a_prev >> 11) & 31);
            sample_q.push_back(t);
            if ((a >> 16) != (a_prev >> 16)) begin
                p++;
                tick_q.push_back(s + 2 + 2 * k);
                if ((blen != 0 && p == blen) ||
                    (stop_c >= s + 2 && stop_c <= s + 1 + 2 * k)) begin
                    d = s + 2 + 2 * k;
                    done_q.push_back(d);
                end
            end
        end
        if (d < 0) d = s + 10;
    endtask

    // Issue one burst, track it with the model, disturb inputs if asked.
    task automatic run_burst(input int fcw, input int blen, input int stop_off,
                             input int ofs, input bit noise, input bit dual_stop,
                             output int s);
        int d, stop_c, cur;
        @(posedge clk); #1;
        s          = cyc;
        stop_c     = (stop_off < 0) ? -1 : s + 2 + stop_off;
        first_tick = -1;
        last_done  = -1;
        bus.start     = 1'b1;
        bus.stop      = dual_stop;
        bus.fcw       = 16'(fcw);
        bus.burst_len = 8'(blen);
`ifdef CARRIER_SEQ_PHASE_EN
        bus.phase_ofs = 5'(ofs);
`endif
        model_burst(s, longint'(fcw), blen, stop_c, ofs, d);
        forever begin
            @(posedge clk); #1;
            cur = cyc;
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            if (cur > d) break;
            if (noise && cur >= s + 2) begin
                bus.start     = ($urandom_range(0, 5) == 0);
                bus.fcw       = 16'($urandom);
                bus.burst_len = 8'($urandom);
            end
            if (cur == stop_c) bus.stop = 1'b1;
        end
        chk("idle_busy", bus.busy, 0);
        chk("idle_blank", bus.blank_DA_n, 0);
        chk("idle_clkda", bus.clk_DA, 0);
        chk("samples_left", sample_q.size(), 0);
        chk("ticks_left", tick_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        sample_q.delete();
        tick_q.delete();
        done_q.delete();
    endtask

    // Monitor: compare every presented sample, tick and done with the queues.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (bus.clk_DA && !prev_cda) begin
                if (sample_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sample_extra: unexpected sample addr %0d at cycle %0d", bus.address, cyc);
                end else begin
                    mon_e = sample_q.pop_front();
                    chk("sample_cyc", cyc, mon_e.cyc);
                    chk("sample_addr", bus.address, mon_e.addr);
                    chk("sample_blank", bus.blank_DA_n, 1);
                end
            end
            if (bus.period_tick) begin
                if (first_tick < 0) first_tick = cyc;
                if (tick_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tick_extra: unexpected period_tick at cycle %0d", cyc);
                end else begin
                    chk("tick_cyc", cyc, tick_q.pop_front());
                end
            end
            if (bus.done) begin
                last_done = cyc;
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_extra: unexpected done at cycle %0d", cyc);
                end else begin
                    chk("done_cyc", cyc, done_q.pop_front());
                    chk("done_busy", bus.busy, 1);
                    chk("done_sync", bus.sync_DA_n, 1);
                end
            end
        end
        prev_cda = bus.clk_DA;
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_blank"}, bus.blank_DA_n, 0);
        chk({tag, "_clkda"}, bus.clk_DA, 0);
        chk({tag, "_addr"}, bus.address, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_tick"}, bus.period_tick, 0);
        chk({tag, "_sync"}, bus.sync_DA_n, 1);
    endtask

    initial begin
        int s, fcw, blen, soff, ofs;
        bit noise, dual;
        errors = 0; checks = 0; mon_en = 1'b0; prev_cda = 1'b0;
        first_tick = -1; last_done = -1;
        reset = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.fcw = '0; bus.burst_len = '0;
`ifdef CARRIER_SEQ_PHASE_EN
        bus.phase_ofs = '0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_reset_state("rst0");

        // Reset held for three cycles in the middle of a running burst.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.fcw = 16'h0800; bus.burst_len = 8'd0;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 chk("rstmid_done1", bus.done, 0);
        @(posedge clk); #1 chk("rstmid_done2", bus.done, 0);
        @(posedge clk); #1 reset = 1'b0;
        chk_reset_state("rstmid");
        @(posedge clk); #1;
        chk("rstmid_busy_after", bus.busy, 0);
        chk("rstmid_done_after", bus.done, 0);
        mon_en = 1'b1;

        // Two-period burst at one address step per sample.
        run_burst(16'h0800, 2, -1, 0, 1'b0, 1'b0, s);
        chk("b2_done_rel", last_done - s, 130);
        chk("b2_tick_rel", first_tick - s, 66);

        // Continuous run, stop mid-period, ends at the following wrap.
        run_burst(16'h1000, 0, 38, 0, 1'b0, 1'b0, s);
        chk("stop_done_rel", last_done - s, 66);

        // Zero FCW: stop ends the burst on the next edge.
        run_burst(0, 0, 8, 0, 1'b0, 1'b0, s);
        chk("fcw0_done_rel", last_done - s, 11);

        // Restart attempts and input changes mid-burst; start+stop together.
        run_burst(16'h0800, 1, -1, 0, 1'b1, 1'b1, s);
        chk("noise_done_rel", last_done - s, 66);

`ifdef CARRIER_SEQ_PHASE_EN
        run_burst(16'h0800, 1, -1, 8, 1'b0, 1'b0, s);
        chk("phase_tick_rel", first_tick - s, 50);
`endif

        // Randomized bursts.
        for (int i = 0; i < 24; i++) begin
            fcw   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(16'h0400, 16'h6000));
            blen  = int'($urandom_range(0, 3));
            noise = 1'($urandom_range(0, 1));
            dual  = 1'($urandom_range(0, 1));
            ofs   = 0;
`ifdef CARRIER_SEQ_PHASE_EN
            ofs   = int'($urandom_range(0, 31));
`endif
            if (fcw == 0)
                soff = int'($urandom_range(0, 40));
            else if (blen == 0 || $urandom_range(0, 2) == 0)
                soff = int'($urandom_range(0, 200));
            else
                soff = -1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_burst(fcw, blen, soff, ofs, noise, dual, s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
